// File: rtl/vita_pkg.sv
// Shared definitions for the VITA-49 RX framer: drain state encoding,
// IF-data header field codes and the header word builder.
package vita_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_HDR    = 4'd1,
    ST_SID    = 4'd2,
    ST_TSI    = 4'd3,
    ST_TSF_HI = 4'd4,
    ST_TSF_LO = 4'd5,
    ST_PAY    = 4'd6,
    ST_TRL    = 4'd7
  } state_e;

  localparam logic [3:0] PKT_TYPE_IFDATA = 4'h1;  // IF data with stream id
  localparam logic [1:0] TSI_UTC         = 2'b01;
  localparam logic [1:0] TSF_SAMPLES     = 2'b01;
  localparam int         TRL_EOB_BIT     = 11;    // end-of-burst flag in trailer
  localparam int         HDR_WORDS       = 5;     // HDR, SID, TSI, TSF_HI, TSF_LO

  // Assemble the first word of an IF-data packet
  function automatic logic [31:0] vita_hdr(input logic       trl,
                                           input logic [3:0] seq,
                                           input logic [15:0] size);
    return {PKT_TYPE_IFDATA, 1'b0, trl, 2'b00, TSI_UTC, TSF_SAMPLES, seq, size};
  endfunction

endpackage

// File: rtl/vita_pp_ram.sv
// Simple dual-port payload RAM for the ping-pong banks.
// Address = {bank, index}; read data is registered (one-cycle latency).
module vita_pp_ram #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW:0]   wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [AW:0]   rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [2**(AW+1)];

  // Write port and registered read port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/vita_rx_framer_pp.sv
// VITA-49 RX framer: strobed 32-bit samples are collected into two ping-pong
// banks and emitted as IF-data packets on a 36-bit FIFO stream.
// Optional trailer word (end-of-burst flag) is enabled by defining
// VITA_RX_TRAILER_EN; without it packets end at the last payload word.
module vita_rx_framer_pp
  import vita_pkg::*;
#(
  parameter int BASE = 0,
  parameter int AW   = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [63:0] vita_time,
  input  logic [31:0] sample,
  input  logic        strobe,
  input  logic        run,
  output logic [35:0] data_o,
  output logic        src_rdy_o,
  input  logic        dst_rdy_i,
  output logic        overrun,
  output logic [31:0] debug
);

`ifdef VITA_RX_TRAILER_EN
  localparam logic TRL_PRESENT = 1'b1;
`else
  localparam logic TRL_PRESENT = 1'b0;
`endif

  localparam logic [7:0]    ADDR_SID = 8'(BASE);
  localparam logic [7:0]    ADDR_SPP = 8'(BASE + 1);
  localparam logic [AW-1:0] NMAX     = '1;
  localparam logic [AW-1:0] ONE      = AW'(1);

  logic [31:0]   streamid_q, streamid_d;
  logic [15:0]   spp_q, spp_d;
  logic [3:0]    seqnum_q, seqnum_d;
  logic          fill_bank_q, fill_bank_d;
  logic          drain_bank_q, drain_bank_d;
  logic [1:0]    bank_full_q, bank_full_d;
  logic [AW-1:0] fill_count_q, fill_count_d;
  logic          run_q, run_d;
  logic [63:0]   ts_q [2];
  logic [63:0]   ts_d [2];
  logic [AW-1:0] len_q [2];
  logic [AW-1:0] len_d [2];
  logic [1:0]    eob_q, eob_d;
  state_e        state_q, state_d;
  logic [AW-1:0] pay_idx_q, pay_idx_d;

  logic          active;
  logic          wr_en;
  logic [AW:0]   cnt_inc;
  logic [AW-1:0] n_eff;
  logic          accept;
  logic          last_pay;
  logic          rel_pkt;
  logic          eof;
  logic [31:0]   word;
  logic [15:0]   pkt_size;
  logic [31:0]   rd_data;

  assign active   = reset & ~clear;
  assign wr_en    = strobe & run & ~bank_full_q[fill_bank_q] & active;
  assign overrun  = strobe & run &  bank_full_q[fill_bank_q] & active;
  assign cnt_inc  = {1'b0, fill_count_q} + (AW+1)'(1);
  assign src_rdy_o = (state_q != ST_IDLE);
  assign accept   = src_rdy_o & dst_rdy_i;
  assign last_pay = (pay_idx_q == len_q[drain_bank_q] - ONE);
  assign pkt_size = 16'(HDR_WORDS) + 16'(len_q[drain_bank_q]) + 16'(TRL_PRESENT);
  assign data_o   = {2'b00, eof, (state_q == ST_HDR), word};
  assign debug    = {4'd0, state_q, fill_bank_q, drain_bank_q, bank_full_q,
                     seqnum_q, 16'(fill_count_q)};

  vita_pp_ram #(.AW(AW)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr ({fill_bank_q, fill_count_q}),
    .wr_data (sample),
    .rd_addr ({drain_bank_q, pay_idx_d}),
    .rd_data (rd_data)
  );

  // Effective packet length: 0 or out-of-range requests saturate to the bank size
  always_comb begin
    n_eff = NMAX;
    if (spp_q != '0 && spp_q <= 16'(NMAX)) n_eff = spp_q[AW-1:0];
  end

  // Settings decode; a new stream id restarts the sequence count
  always_comb begin
    streamid_d = streamid_q;
    spp_d      = spp_q;
    seqnum_d   = seqnum_q;
    if (rel_pkt) seqnum_d = seqnum_q + 4'd1;
    if (set_stb && set_addr == ADDR_SID) begin
      streamid_d = set_data;
      seqnum_d   = '0;
    end
    if (set_stb && set_addr == ADDR_SPP) spp_d = set_data[15:0];
  end

  // Fill side: store samples, latch timestamps, close banks on length or run drop
  always_comb begin
    fill_bank_d  = fill_bank_q;
    fill_count_d = fill_count_q;
    bank_full_d  = bank_full_q;
    ts_d         = ts_q;
    len_d        = len_q;
    eob_d        = eob_q;
    run_d        = run;
    if (wr_en) begin
      if (fill_count_q == '0) ts_d[fill_bank_q] = vita_time;
      if (cnt_inc >= {1'b0, n_eff}) begin
        len_d[fill_bank_q]       = cnt_inc[AW-1:0];
        eob_d[fill_bank_q]       = 1'b0;
        bank_full_d[fill_bank_q] = 1'b1;
        fill_bank_d              = ~fill_bank_q;
        fill_count_d             = '0;
      end else begin
        fill_count_d = cnt_inc[AW-1:0];
      end
    end else if (run_q && !run && fill_count_q != '0) begin
      len_d[fill_bank_q]       = fill_count_q;
      eob_d[fill_bank_q]       = 1'b1;
      bank_full_d[fill_bank_q] = 1'b1;
      fill_bank_d              = ~fill_bank_q;
      fill_count_d             = '0;
    end
    // Release of the draining bank takes priority over any set on it
    if (rel_pkt) bank_full_d[drain_bank_q] = 1'b0;
  end

  // Drain FSM: next state, output word and prefetched payload read index
  always_comb begin
    state_d      = state_q;
    pay_idx_d    = '0;
    rel_pkt      = 1'b0;
    eof          = 1'b0;
    word         = '0;
    drain_bank_d = drain_bank_q;
    case (state_q)
      ST_IDLE:   if (bank_full_q[drain_bank_q]) state_d = ST_HDR;
      ST_HDR: begin
        word = vita_hdr(TRL_PRESENT, seqnum_q, pkt_size);
        if (accept) state_d = ST_SID;
      end
      ST_SID: begin
        word = streamid_q;
        if (accept) state_d = ST_TSI;
      end
      ST_TSI: begin
        word = ts_q[drain_bank_q][63:32];
        if (accept) state_d = ST_TSF_HI;
      end
      ST_TSF_HI: begin
        word = '0;
        if (accept) state_d = ST_TSF_LO;
      end
      ST_TSF_LO: begin
        word = ts_q[drain_bank_q][31:0];
        if (accept) state_d = ST_PAY;
      end
      ST_PAY: begin
        word      = rd_data;
        eof       = last_pay & ~TRL_PRESENT;
        pay_idx_d = pay_idx_q;
        if (accept) begin
          if (last_pay) begin
            pay_idx_d = '0;
            if (TRL_PRESENT) begin
              state_d = ST_TRL;
            end else begin
              state_d = ST_IDLE;
              rel_pkt = 1'b1;
            end
          end else begin
            pay_idx_d = pay_idx_q + ONE;
          end
        end
      end
      ST_TRL: begin
        word[TRL_EOB_BIT] = eob_q[drain_bank_q];
        eof               = 1'b1;
        if (accept) begin
          state_d = ST_IDLE;
          rel_pkt = 1'b1;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
    if (rel_pkt) drain_bank_d = ~drain_bank_q;
  end

  // Settings registers survive clear, only reset zeroes them
  always_ff @(posedge clk) begin
    if (!reset) begin
      streamid_q <= '0;
      spp_q      <= '0;
    end else begin
      streamid_q <= streamid_d;
      spp_q      <= spp_d;
    end
  end

  // Control state, flushed by reset or clear
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      state_q      <= ST_IDLE;
      seqnum_q     <= '0;
      fill_bank_q  <= 1'b0;
      drain_bank_q <= 1'b0;
      bank_full_q  <= '0;
      fill_count_q <= '0;
      run_q        <= 1'b0;
      pay_idx_q    <= '0;
    end else begin
      state_q      <= state_d;
      seqnum_q     <= seqnum_d;
      fill_bank_q  <= fill_bank_d;
      drain_bank_q <= drain_bank_d;
      bank_full_q  <= bank_full_d;
      fill_count_q <= fill_count_d;
      run_q        <= run_d;
      pay_idx_q    <= pay_idx_d;
    end
  end

  // Per-bank packet metadata; only meaningful while the bank is marked full
  always_ff @(posedge clk) begin
    ts_q  <= ts_d;
    len_q <= len_d;
    eob_q <= eob_d;
  end

endmodule
